// File: rtl/pacman_sound_pkg.sv
// Shared definitions for the Pacman buzzer sound path: FSM state encoding
// and the default tone/melody tables.
package pacman_sound_pkg;

  localparam int DEF_DIV_W = 15;
  localparam int DEF_DUR_W = 24;

  // Packed half-period tables, entry 0 in the least significant slot.
  localparam logic [4*DEF_DIV_W-1:0] DEF_KEY_TABLE =
    {15'd6250, 15'd8333, 15'd12500, 15'd25000};
  localparam logic [4*DEF_DIV_W-1:0] DEF_MELODY_TABLE =
    {15'd16000, 15'd12500, 15'd10000, 15'd8000};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_NOTE,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/square_divider.sv
// Square-wave generator: toggles the speaker every half_period cycles and
// restarts cleanly whenever the requested half-period changes.
module square_divider #(
  parameter int DIV_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] half_period,
  input  logic             mute,
  output logic             speaker
);

  logic [DIV_W-1:0] hp_q;
  logic [DIV_W-1:0] div_cnt;
  logic             spk_q;
  logic             changed;
  logic [DIV_W-1:0] cnt_cur;
  logic             spk_cur;

  assign changed = (half_period != hp_q);

  // A new half-period counts as a fresh start, so its first cycle already
  // counts toward the first toggle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_cur = div_cnt;
    spk_cur = spk_q;
    if (changed) begin
      cnt_cur = '0;
      spk_cur = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only; blocking here
  // would create ordering races between always_ff blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      hp_q    <= '0;
      div_cnt <= '0;
      spk_q   <= 1'b0;
    end else begin
      hp_q <= half_period;
      if (half_period == '0 || mute) begin
        div_cnt <= '0;
        spk_q   <= 1'b0;
      end else if (cnt_cur == half_period - 1'b1) begin
        div_cnt <= '0;
        spk_q   <= ~spk_cur;
      end else begin
        div_cnt <= cnt_cur + 1'b1;
        spk_q   <= spk_cur;
      end
    end
  end

  // Silence immediately on a half-period change or mute, before the
  // registers catch up on the next edge.
  assign speaker = spk_q & ~changed & ~mute;

endmodule

// File: rtl/tone_sequencer.sv
// Buzzer sound-effect sequencer: sustained key tones from a lookup table and
// a timed multi-note game-over melody, driving a square-wave speaker.
module tone_sequencer
  import pacman_sound_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int CODE_W   = 2,
  parameter int SEQ_LEN  = 4,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int NOTE_DUR = 12500000,
  parameter int GAP_DUR  = 1250000,
  parameter logic [(2**CODE_W)*DIV_W-1:0] KEY_TABLE    = DEF_KEY_TABLE,
  parameter logic [SEQ_LEN*DIV_W-1:0]     MELODY_TABLE = DEF_MELODY_TABLE,
  localparam int SEQ_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic              pressed,
  input  logic              game_over,
  input  logic              mute,
  output logic              speaker,
  output logic              busy,
  output logic [DIV_W-1:0]  half_period,
  output logic [SEQ_W-1:0]  seq_idx
);

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_DUR - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_DUR > 0) ? GAP_DUR - 1 : 0);
  localparam logic [SEQ_W-1:0] SEQ_LAST  = SEQ_W'(SEQ_LEN - 1);

  // Durations must fit their counter and a note must last at least a cycle.
  if (NOTE_DUR < 1 || GAP_DUR < 0 || SEQ_LEN < 1 || CODE_W < 1 ||
      longint'(NOTE_DUR) >= (longint'(1) << DUR_W) ||
      longint'(GAP_DUR) >= (longint'(1) << DUR_W)) begin : g_bad_params
    $error("tone_sequencer: NOTE_DUR/GAP_DUR/SEQ_LEN out of range for DUR_W");
  end

  state_t           state;
  logic [DUR_W-1:0] dur_cnt;
  logic             game_over_q;
  logic             rise;
  logic             seg_end;
  logic [SEQ_W-1:0] next_idx;

  function automatic logic [DIV_W-1:0] key_hp(input logic [CODE_W-1:0] c);
    return KEY_TABLE[c*DIV_W +: DIV_W];
  endfunction

  function automatic logic [DIV_W-1:0] melody_hp(input logic [SEQ_W-1:0] i);
    return MELODY_TABLE[i*DIV_W +: DIV_W];
  endfunction

  assign rise     = game_over & ~game_over_q;
  assign seg_end  = (state == ST_NOTE) ? (dur_cnt == NOTE_LAST) : (dur_cnt == GAP_LAST);
  assign next_idx = seq_idx + 1'b1;

  // half_period and busy are registered alongside the state so they always
  // describe the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      half_period <= '0;
      busy        <= 1'b0;
      seq_idx     <= '0;
      dur_cnt     <= '0;
      game_over_q <= 1'b0;
    end else begin
      game_over_q <= game_over;
      case (state)
        ST_IDLE, ST_KEY: begin
          if (rise) begin
            state       <= ST_NOTE;
            seq_idx     <= '0;
            dur_cnt     <= '0;
            half_period <= melody_hp('0);
            busy        <= 1'b1;
          end else if (pressed) begin
            state       <= ST_KEY;
            half_period <= key_hp(code);
          end else begin
            state       <= ST_IDLE;
            half_period <= '0;
          end
        end

        ST_NOTE, ST_GAP: begin
          if (!game_over) begin
            // A new game has started: abandon the melody.
            state       <= ST_IDLE;
            seq_idx     <= '0;
            dur_cnt     <= '0;
            half_period <= '0;
            busy        <= 1'b0;
          end else if (!seg_end) begin
            dur_cnt <= dur_cnt + 1'b1;
          end else begin
            dur_cnt <= '0;
            if (state == ST_NOTE && GAP_DUR > 0) begin
              state       <= ST_GAP;
              half_period <= '0;
            end else if (seq_idx == SEQ_LAST) begin
              state       <= ST_DONE;
              half_period <= '0;
              busy        <= 1'b0;
            end else begin
              state       <= ST_NOTE;
              seq_idx     <= next_idx;
              half_period <= melody_hp(next_idx);
            end
          end
        end

        ST_DONE: begin
          if (!game_over) begin
            state   <= ST_IDLE;
            seq_idx <= '0;
          end
        end

        default: begin
          state       <= ST_IDLE;
          seq_idx     <= '0;
          dur_cnt     <= '0;
          half_period <= '0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  square_divider #(
    .DIV_W(DIV_W)
  ) u_divider (
    .clk        (clk),
    .rst        (rst),
    .half_period(half_period),
    .mute       (mute),
    .speaker    (speaker)
  );

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: key tones, mute, melody timing, abort,
// and a back-to-back (no gap) melody build running alongside.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  code;
  logic        pressed;
  logic        game_over;
  logic        mute;

  logic        speaker, speaker2;
  logic        busy, busy2;
  logic [14:0] half_period, half_period2;
  logic [1:0]  seq_idx, seq_idx2;

  int checks = 0;
  int errors = 0;

  // Key table entries 0..3 = 1,3,2,4; melody notes 0..3 = 2,4,6,0 (rest).
  localparam logic [59:0] KEY_TBL = {15'd4, 15'd2, 15'd3, 15'd1};
  localparam logic [59:0] MEL_TBL = {15'd0, 15'd6, 15'd4, 15'd2};
  int mel [4] = '{2, 4, 6, 0};

  always #5 clk = ~clk;

  tone_sequencer #(
    .DIV_W(15), .CODE_W(2), .SEQ_LEN(4), .DUR_W(8),
    .NOTE_DUR(20), .GAP_DUR(3),
    .KEY_TABLE(KEY_TBL), .MELODY_TABLE(MEL_TBL)
  ) dut (
    .clk(clk), .rst(rst), .code(code), .pressed(pressed),
    .game_over(game_over), .mute(mute),
    .speaker(speaker), .busy(busy), .half_period(half_period), .seq_idx(seq_idx)
  );

  tone_sequencer #(
    .DIV_W(15), .CODE_W(2), .SEQ_LEN(4), .DUR_W(8),
    .NOTE_DUR(20), .GAP_DUR(0),
    .KEY_TABLE(KEY_TBL), .MELODY_TABLE(MEL_TBL)
  ) dut_nogap (
    .clk(clk), .rst(rst), .code(code), .pressed(pressed),
    .game_over(game_over), .mute(mute),
    .speaker(speaker2), .busy(busy2), .half_period(half_period2), .seq_idx(seq_idx2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] key_spk;
    logic [4:0] key0_spk;
    logic [3:0] unmute_spk;
    int note, pos;

    rst = 1'b1; code = 2'd2; pressed = 1'b1; game_over = 1'b0; mute = 1'b0;

    // Reset held with a key pressed
    tick(2);
    check("rst_speaker", speaker, 0);
    check("rst_busy", busy, 0);
    check("rst_half_period", half_period, 0);
    check("rst_seq_idx", seq_idx, 0);

    // Key tone, code 2 -> half-period 2, period 4
    rst = 1'b0;
    tick(1);
    check("key2_half_period", half_period, 2);
    key_spk = 8'b1100_1100;  // bit i = expected speaker i edges after entry
    check("key2_spk_0", speaker, key_spk[0]);
    for (int i = 1; i < 8; i++) begin
      tick(1);
      check($sformatf("key2_spk_%0d", i), speaker, key_spk[i]);
    end

    // Code 0 mid-tone -> half-period 1, divider restarts from silence
    code = 2'd0;
    key0_spk = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (i == 0) check("key0_half_period", half_period, 1);
      check($sformatf("key0_spk_%0d", i), speaker, key0_spk[i]);
    end

    // Release key
    pressed = 1'b0;
    tick(1);
    check("release_half_period", half_period, 0);
    check("release_spk", speaker, 0);
    tick(1);
    check("idle_spk", speaker, 0);

    // Mute during a key tone
    pressed = 1'b1; code = 2'd2;
    tick(3);
    check("premute_spk", speaker, 1);
    mute = 1'b1;
    tick(1);
    check("mute_spk_a", speaker, 0);
    check("mute_half_period", half_period, 2);
    tick(1);
    check("mute_spk_b", speaker, 0);
    mute = 1'b0;
    unmute_spk = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("unmute_spk_%0d", i), speaker, unmute_spk[i]);
    end

    // Melody preempts a held key (code 3 -> half-period 4 first)
    code = 2'd3;
    tick(1);
    check("key3_half_period", half_period, 4);
    game_over = 1'b1;
    tick(1);
    check("mel_start_busy", busy, 1);
    check("mel_start_half_period", half_period, 2);
    check("mel_start_seq", seq_idx, 0);
    check("mel_start_spk", speaker, 0);
    check("nogap_start_busy", busy2, 1);
    for (int g = 1; g <= 92; g++) begin
      tick(1);
      if (g < 92) begin
        note = g / 23;
        pos  = g % 23;
        check($sformatf("mel_hp_%0d", g), half_period, (pos < 20) ? mel[note] : 0);
        check($sformatf("mel_busy_%0d", g), busy, 1);
        check($sformatf("mel_seq_%0d", g), seq_idx, note);
        if (note == 3) check($sformatf("mel_rest_spk_%0d", g), speaker, 0);
      end else begin
        check("mel_done_busy", busy, 0);
        check("mel_done_half_period", half_period, 0);
        check("mel_done_seq", seq_idx, 3);
      end
      if (g < 80) begin
        check($sformatf("nogap_hp_%0d", g), half_period2, mel[g / 20]);
        check($sformatf("nogap_seq_%0d", g), seq_idx2, g / 20);
        check($sformatf("nogap_busy_%0d", g), busy2, 1);
      end else begin
        check($sformatf("nogap_done_busy_%0d", g), busy2, 0);
        check($sformatf("nogap_done_hp_%0d", g), half_period2, 0);
      end
      if (g == 2)  check("mel_note0_spk", speaker, 1);
      if (g == 27) check("mel_note1_spk", speaker, 1);
      if (g == 19) check("nogap_pre_boundary_spk", speaker2, 1);
      if (g == 20) check("nogap_boundary_spk", speaker2, 0);
      if (g == 23) check("nogap_restart_spk_a", speaker2, 0);
      if (g == 24) check("nogap_restart_spk_b", speaker2, 1);
    end

    // Leave DONE
    game_over = 1'b0; pressed = 1'b0;
    tick(1);
    check("done_exit_busy", busy, 0);
    check("done_exit_half_period", half_period, 0);
    tick(1);
    check("idle_half_period", half_period, 0);

    // Abort during note 1, then restart
    game_over = 1'b1;
    tick(1);
    check("abort_start_busy", busy, 1);
    check("abort_start_half_period", half_period, 2);
    tick(23);
    check("abort_note1_seq", seq_idx, 1);
    check("abort_note1_half_period", half_period, 4);
    tick(4);
    check("abort_note1_spk", speaker, 1);
    game_over = 1'b0;
    tick(1);
    check("abort_busy", busy, 0);
    check("abort_seq", seq_idx, 0);
    check("abort_half_period", half_period, 0);
    check("abort_spk", speaker, 0);
    game_over = 1'b1;
    tick(1);
    check("restart_busy", busy, 1);
    check("restart_seq", seq_idx, 0);
    check("restart_half_period", half_period, 2);

    // Reset mid-melody
    tick(5);
    rst = 1'b1;
    tick(1);
    check("midrst_busy", busy, 0);
    check("midrst_half_period", half_period, 0);
    check("midrst_spk", speaker, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Parametrised sound-effect generator for the Pacman buzzer, succeeding the fixed code-to-frequency mapping.
- Maps direction keypresses to sustained tones from a table.
- Plays a multi-note game-over melody with per-note duration and inter-note gap.
- Produces the square-wave speaker output directly.
- Sits between the input/game-state logic and the buzzer pin.

Parameters:
DIV_W, 15, width of half-period values in clock cycles.
CODE_W, 2, width of key code; table has 2**CODE_W entries.
SEQ_LEN, 4, number of melody notes.
DUR_W, 24, width of note/gap duration counters.
NOTE_DUR, 12500000, melody note length in cycles (must be ≥1).
GAP_DUR, 1250000, silent gap after each note in cycles (0 = no gap).
KEY_TABLE, {6250,8333,12500,25000} packed, entry i at bits [i*DIV_W +: DIV_W] (entry 0 = 25000); half-period per code.
MELODY_TABLE, {16000,12500,10000,8000} packed, same packing (note 0 = 8000); half-period per note, 0 = rest.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
code  in  CODE_W  key/direction code
pressed  in  1  key held (level)
game_over  in  1  game-over level
mute  in  1  forces silence, FSM keeps running
speaker  out  1  square wave to buzzer
busy  out  1  melody in progress
half_period  out  DIV_W  currently selected half-period, 0 = silent
seq_idx  out  clog2(SEQ_LEN)  current melody note index

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE, speaker=0, busy=0, half_period=0, seq_idx=0, all counters 0, game_over edge register 0.
- Tone divider:
  - div_cnt increments each cycle while half_period≠0 and mute=0.
  - At div_cnt==half_period-1: speaker toggles, div_cnt→0.
  - Output period = 2*half_period cycles.
  - When half_period changes value, div_cnt→0 and speaker→0 on that same edge.
  - half_period==0 or mute=1: speaker=0, div_cnt=0.
- game_over rise = game_over & ~game_over_q (registered previous value).
- FSM:
  - IDLE: half_period=0. Transitions:
    - rise → NOTE with seq_idx=0, dur_cnt=0.
    - else pressed → KEY.
  - KEY: half_period=KEY_TABLE[code], re-evaluated every cycle. Transitions:
    - rise → NOTE (priority over pressed).
    - pressed=0 → IDLE next cycle.
  - NOTE: half_period=MELODY_TABLE[seq_idx]; dur_cnt counts 0..NOTE_DUR-1.
    - At NOTE_DUR-1 → GAP, or directly to the next note / DONE if GAP_DUR=0.
  - GAP: half_period=0 for GAP_DUR cycles.
    - If seq_idx==SEQ_LEN-1 → DONE.
    - Else seq_idx+1 → NOTE.
  - DONE: silent, seq_idx held; game_over=0 → IDLE.
  - NOTE/GAP with game_over=0: abort to IDLE next cycle, seq_idx→0 (new game started).
  - pressed ignored in NOTE, GAP and DONE.
- busy=1 exactly in NOTE and GAP; registered, asserted the cycle after rise is sampled.
- Latency: code/state change to half_period update is 1 cycle; first speaker toggle follows half_period cycles later.
- Melody length = SEQ_LEN*(NOTE_DUR+GAP_DUR) cycles from NOTE entry to DONE.
- Widths: all table entries < 2**DIV_W; NOTE_DUR, GAP_DUR < 2**DUR_W. Elaboration-time check fails otherwise.
- Reset mid-melody returns to IDLE silent on the same edge.

Decomposition:
- Shared package pacman_sound_pkg:
  - state encoding (IDLE, KEY, NOTE, GAP, DONE)
  - default KEY_TABLE and MELODY_TABLE constants
  - default DIV_W/DUR_W
- Sub-module square_divider (half_period in, mute in, speaker out, counter and change detection) is natural. The FSM and tables stay in tone_sequencer.

Test Plan:
- Bench overrides: KEY_TABLE={4,3,2,1}-style small values, MELODY_TABLE={0,6,4,2}, NOTE_DUR=20, GAP_DUR=3.
- Reset: hold rst 2 cycles with pressed=1 → speaker=0, busy=0, half_period=0, seq_idx=0. After release, half_period=KEY_TABLE[code] one cycle later.
- Key tone: code=2, pressed=1 → half_period=2, speaker toggles every 2 cycles (period 4). Code→0 mid-tone → half_period=1, div restarts, speaker=0 then toggles every cycle. pressed=0 → half_period=0 next cycle, speaker=0.
- Melody: pressed=1, then game_over rises → KEY preempted, busy=1.
  - Note 0 half_period=2 for 20 cycles, then 3 silent cycles.
  - Note 1 half_period=4; note 3 half_period=0 (rest, speaker stays 0).
  - DONE after 4*23=92 cycles with busy=0.
  - game_over=0 → IDLE.
- Abort: drop game_over during note 1 → IDLE next cycle, busy=0, seq_idx=0, speaker=0. Re-raise → melody restarts at note 0.
- Mute: mute=1 during key tone → speaker=0, half_period unchanged. Release → toggling resumes from div_cnt=0.
- GAP_DUR=0 build: notes back-to-back, total 80 cycles; half_period change restarts divider at each note boundary.
